// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that shares one EX stage between two requesters.
// Latches the winner's operands, kicks EX, and returns result/err with a WAIT timeout.
module alu_arbiter #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [3:0]        op0,
  input  logic [3:0]        op1,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] b0,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] result0,
  output logic [DATA_W-1:0] result1,
  output logic              err0,
  output logic              err1,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_start,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            r_state, w_state_nxt;
  logic [7:0]        r_cnt, w_cnt_nxt;
  logic              r_win, w_win_nxt;
  logic              r_last, w_last_nxt;
  logic              r_gnt0, w_gnt0_nxt, r_gnt1, w_gnt1_nxt;
  logic              r_rvalid0, w_rvalid0_nxt, r_rvalid1, w_rvalid1_nxt;
  logic              r_err0, w_err0_nxt, r_err1, w_err1_nxt;
  logic [DATA_W-1:0] r_result0, w_result0_nxt, r_result1, w_result1_nxt;
  logic [3:0]        r_alu_op, w_alu_op_nxt;
  logic [DATA_W-1:0] r_alu_a, w_alu_a_nxt, r_alu_b, w_alu_b_nxt;
  logic              r_alu_start, w_alu_start_nxt;
  logic              w_pick, w_fin, w_fin_err;
  logic [DATA_W-1:0] w_fin_res;

  // On a tie the requester that was not served last wins; r_last resets to 1 so requester 0 wins first.
  assign w_pick = (req0 && req1) ? ~r_last : req1;

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_win_nxt       = r_win;
    w_last_nxt      = r_last;
    w_gnt0_nxt      = 1'b0;
    w_gnt1_nxt      = 1'b0;
    w_rvalid0_nxt   = 1'b0;
    w_rvalid1_nxt   = 1'b0;
    w_err0_nxt      = 1'b0;
    w_err1_nxt      = 1'b0;
    w_result0_nxt   = r_result0;
    w_result1_nxt   = r_result1;
    w_alu_op_nxt    = r_alu_op;
    w_alu_a_nxt     = r_alu_a;
    w_alu_b_nxt     = r_alu_b;
    w_alu_start_nxt = 1'b0;
    w_fin           = 1'b0;
    w_fin_err       = 1'b0;
    w_fin_res       = {DATA_W{1'b0}};
    case (r_state)
      S_IDLE: begin
        if (req0 || req1) begin
          w_win_nxt       = w_pick;
          w_gnt0_nxt      = ~w_pick;
          w_gnt1_nxt      = w_pick;
          w_alu_start_nxt = 1'b1;
          w_alu_op_nxt    = w_pick ? op1 : op0;
          w_alu_a_nxt     = w_pick ? a1 : a0;
          w_alu_b_nxt     = w_pick ? b1 : b0;
          w_state_nxt     = S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        w_cnt_nxt   = 8'd0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving in the last allowed WAIT cycle still beats the timeout.
        if (alu_done) begin
          w_fin     = 1'b1;
          w_fin_res = alu_result;
        end else if (r_cnt == CNT_LAST) begin
          w_fin     = 1'b1;
          w_fin_err = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_fin) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = 8'd0;
      w_last_nxt  = r_win;
      if (r_win) begin
        w_rvalid1_nxt = 1'b1;
        w_err1_nxt    = w_fin_err;
        w_result1_nxt = w_fin_res;
      end else begin
        w_rvalid0_nxt = 1'b1;
        w_err0_nxt    = w_fin_err;
        w_result0_nxt = w_fin_res;
      end
    end else begin
      w_last_nxt = r_last;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_win       <= 1'b0;
      r_last      <= 1'b1;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_err0      <= 1'b0;
      r_err1      <= 1'b0;
      r_result0   <= {DATA_W{1'b0}};
      r_result1   <= {DATA_W{1'b0}};
      r_alu_op    <= 4'd0;
      r_alu_a     <= {DATA_W{1'b0}};
      r_alu_b     <= {DATA_W{1'b0}};
      r_alu_start <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_win       <= w_win_nxt;
      r_last      <= w_last_nxt;
      r_gnt0      <= w_gnt0_nxt;
      r_gnt1      <= w_gnt1_nxt;
      r_rvalid0   <= w_rvalid0_nxt;
      r_rvalid1   <= w_rvalid1_nxt;
      r_err0      <= w_err0_nxt;
      r_err1      <= w_err1_nxt;
      r_result0   <= w_result0_nxt;
      r_result1   <= w_result1_nxt;
      r_alu_op    <= w_alu_op_nxt;
      r_alu_a     <= w_alu_a_nxt;
      r_alu_b     <= w_alu_b_nxt;
      r_alu_start <= w_alu_start_nxt;
    end
  end

  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign rvalid0   = r_rvalid0;
  assign rvalid1   = r_rvalid1;
  assign err0      = r_err0;
  assign err1      = r_err1;
  assign result0   = r_result0;
  assign result1   = r_result1;
  assign alu_op    = r_alu_op;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_start = r_alu_start;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized scoreboard bench for alu_arbiter with a behavioural EX stand-in.
// The reference model predicts service order, result, err and latency per operation.
module tb_alu_arbiter;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [3:0]    op0 = 4'd0, op1 = 4'd0;
  logic [DW-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, err0, err1, alu_start;
  logic [DW-1:0] result0, result1, alu_a, alu_b;
  logic [3:0]    alu_op;
  logic [DW-1:0] alu_result = '0;
  logic          alu_done = 1'b0;

  typedef struct {
    int            who;
    logic [DW-1:0] res;
    logic          err;
    int            lat;
  } exp_t;

  exp_t          exp_q[$];
  int            gnt_q[$];
  int            ex_q[$];
  int            gnt_log[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            rv_count = 0;
  int            kick_req = 0;
  int            kick_done = 0;
  int            m_last = 1;
  logic [DW-1:0] m_res [2];
  int            first_wait [2];

  alu_arbiter #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .result0(result0), .result1(result1), .err0(err0), .err1(err1),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start),
    .alu_result(alu_result), .alu_done(alu_done)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Stand-in EX stage opcode semantics (0 ADD ... 8 SHIFT_RIGHT).
  function automatic logic [DW-1:0] ref_alu(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ~(a | b);
      4'd6: return (a < b) ? 32'd1 : 32'd0;
      4'd7: return a << b[4:0];
      4'd8: return a >> b[4:0];
      default: return a;
    endcase
  endfunction

  // EX latency in WAIT cycles; 0 means EX never answers.
  function automatic int pick_lat();
    int r;
    r = int'($urandom_range(4, 0));
    return (r == 4) ? TO : r;
  endfunction

  // Reference model: service order from the round-robin rule, pushed at stimulus time.
  task automatic plan(input int n0, input int n1, input int fixed_lat);
    int   c [2];
    int   w;
    int   lat;
    exp_t e;
    c[0] = n0;
    c[1] = n1;
    while (c[0] + c[1] > 0) begin
      if (c[0] > 0 && c[1] > 0) w = 1 - m_last;
      else w = (c[0] > 0) ? 0 : 1;
      lat   = (fixed_lat >= 0) ? fixed_lat : pick_lat();
      e.who = w;
      e.err = (lat == 0);
      e.res = (lat == 0) ? '0 : ref_alu(w ? op1 : op0, w ? a1 : a0, w ? b1 : b0);
      e.lat = (lat == 0) ? TO + 1 : lat + 1;
      exp_q.push_back(e);
      gnt_q.push_back(w);
      ex_q.push_back(lat);
      m_res[w] = e.res;
      m_last   = w;
      c[w]--;
    end
  endtask

  task automatic drive_req(input int r, input int n);
    int k;
    if (n > 0) begin
      @(posedge clk); #1;
      if (r == 0) req0 = 1'b1; else req1 = 1'b1;
      for (int i = 0; i < n; i++) begin
        k = 0;
        do begin
          @(posedge clk);
          k++;
          @(negedge clk);
        end while (!((r == 0) ? gnt0 : gnt1) && k < 200);
        if (!((r == 0) ? gnt0 : gnt1)) begin
          chk("gnt_seen", 64'd0, 64'd1);
          break;
        end
        if (i == 0) first_wait[r] = k;
      end
      if (r == 0) req0 = 1'b0; else req1 = 1'b0;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(negedge clk);
    chk("drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_round(input int n0, input int n1, input int fixed_lat);
    plan(n0, n1, fixed_lat);
    fork
      drive_req(0, n0);
      drive_req(1, n1);
    join
    drain();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({gnt0, gnt1, rvalid0, rvalid1, err0, err1, alu_start}), 64'd0);
    chk({tag, "_result0"}, 64'(result0), 64'd0);
    chk({tag, "_result1"}, 64'(result1), 64'd0);
    chk({tag, "_alu_opab"}, 64'(alu_op) | 64'(alu_a) | 64'(alu_b), 64'd0);
  endtask

  // Monitor: pops the scoreboard on every grant and completion.
  initial forever begin
    exp_t e;
    int   last_gnt_cyc;
    @(negedge clk);
    if (gnt0 || gnt1 || alu_start) begin
      chk("gnt_not_both", 64'(gnt0 & gnt1), 64'd0);
      chk("start_with_gnt", 64'(alu_start), 64'(gnt0 | gnt1));
      if (gnt0 || gnt1) begin
        last_gnt_cyc = cyc;
        gnt_log.push_back(gnt1 ? 1 : 0);
        if (gnt_q.size() == 0) chk("gnt_expected", 64'd0, 64'd1);
        else chk("gnt_who", 64'(gnt1), 64'(gnt_q.pop_front()));
      end
    end
    if (rvalid0 || rvalid1) begin
      rv_count++;
      chk("rvalid_not_both", 64'(rvalid0 & rvalid1), 64'd0);
      if (exp_q.size() == 0) chk("rvalid_expected", 64'd0, 64'd1);
      else begin
        e = exp_q.pop_front();
        chk("rvalid_who", 64'(rvalid1), 64'(e.who));
        chk("result", 64'(rvalid1 ? result1 : result0), 64'(e.res));
        chk("err", 64'(rvalid1 ? err1 : err0), 64'(e.err));
        chk("latency", 64'(cyc - last_gnt_cyc), 64'(e.lat));
      end
    end
  end

  // EX stand-in: answers each kick after its planned latency; also injects stray done pulses.
  initial forever begin
    int            lat;
    logic [3:0]    cop;
    logic [DW-1:0] ca, cb;
    @(negedge clk);
    if (alu_start) begin
      if (ex_q.size() == 0) chk("ex_planned", 64'd0, 64'd1);
      else begin
        lat = ex_q.pop_front();
        cop = alu_op;
        ca  = alu_a;
        cb  = alu_b;
        if (lat > 0) begin
          repeat (lat) @(posedge clk);
          #1;
          chk("operands_stable", 64'({alu_op, alu_a, alu_b} == {cop, ca, cb}), 64'd1);
          alu_result = ref_alu(cop, ca, cb);
          alu_done   = 1'b1;
          @(posedge clk); #1;
          alu_done = 1'b0;
        end
      end
    end else if (kick_done != kick_req) begin
      kick_done++;
      @(posedge clk); #1;
      alu_result = 32'hDEAD_BEEF;
      alu_done   = 1'b1;
      @(posedge clk); #1;
      alu_done = 1'b0;
    end
  end

  initial begin
    int rv0;
    int n0, n1;
    m_res[0] = '0;
    m_res[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Both requesters held for two operations each: alternating grants from requester 0.
    op0 = 4'd1; a0 = 32'd100; b0 = 32'd30;
    op1 = 4'd4; a1 = 32'h0F0F_0F0F; b1 = 32'hFFFF_0000;
    run_round(2, 2, 1);
    chk("rr_count", 64'(gnt_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) chk("rr_order", 64'(gnt_log[i]), 64'(i % 2));

    // Single ADD 5+7 with a 1-cycle EX.
    op0 = 4'd0; a0 = 32'd5; b0 = 32'd7;
    run_round(1, 0, 1);
    chk("add_gnt_latency", 64'(first_wait[0]), 64'd1);
    chk("add_result0", 64'(result0), 64'd12);

    // EX never answers: error completion after TIMEOUT WAIT cycles.
    op1 = 4'd2; a1 = $urandom; b1 = $urandom;
    run_round(0, 1, 0);
    chk("timeout_result1", 64'(result1), 64'd0);

    // Done in the last WAIT cycle beats the timeout; FSM must be idle again for a 1-cycle grant.
    op1 = 4'd3; a1 = $urandom; b1 = $urandom;
    run_round(0, 1, TO);
    chk("lastcycle_gnt_latency", 64'(first_wait[1]), 64'd1);
    chk("lastcycle_result1", 64'(result1), 64'(a1 | b1));

    for (int r = 0; r < 30; r++) begin
      n0  = int'($urandom_range(2, 0));
      n1  = (n0 == 0) ? int'($urandom_range(2, 1)) : int'($urandom_range(2, 0));
      op0 = 4'($urandom_range(8, 0)); a0 = $urandom; b0 = $urandom;
      op1 = 4'($urandom_range(8, 0)); a1 = $urandom; b1 = $urandom;
      run_round(n0, n1, -1);
    end

    // Stray alu_done while idle.
    rv0 = rv_count;
    kick_req++;
    repeat (6) @(negedge clk);
    chk("idle_done_no_rvalid", 64'(rv_count), 64'(rv0));
    chk("idle_done_result0", 64'(result0), 64'(m_res[0]));
    chk("idle_done_result1", 64'(result1), 64'(m_res[1]));

    // Reset while waiting on EX aborts the operation silently.
    op0 = 4'd0; a0 = $urandom; b0 = $urandom;
    plan(1, 0, 0);
    drive_req(0, 1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_zero("midop_reset");
    exp_q.delete();
    gnt_q.delete();
    rv0 = rv_count;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    m_last   = 1;
    m_res[0] = '0;
    m_res[1] = '0;
    kick_req++;
    repeat (6) @(negedge clk);
    chk("reset_no_rvalid", 64'(rv_count), 64'(rv0));
    chk("reset_result0", 64'(result0), 64'd0);
    op1 = 4'd8; a1 = 32'h8000_0000; b1 = 32'd4;
    run_round(0, 1, 1);
    chk("post_reset_gnt_latency", 64'(first_wait[1]), 64'd1);
    chk("post_reset_result1", 64'(result1), 64'h0800_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
